// File: rtl/aes_pkg.sv
// Shared AES field arithmetic, datapath types and FSM encoding for the
// iterative MixColumns block.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef logic [7:0] byte_t;
  // Row r of a column lives at index 3-r; column c of a state at index 3-c,
  // so a plain 128-bit assignment keeps byte 0 in the top bits.
  typedef byte_t   [3:0] column_t;
  typedef column_t [3:0] aes_state_t;
  typedef byte_t   [3:0] coef_set_t;

  localparam coef_set_t FWD_COEFS = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam coef_set_t INV_COEFS = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } mc_state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Coefficients below 16 reduce to an XOR of the x1/x2/x4/x8 xtime chain.
  function automatic byte_t gf_mul_small(input byte_t b, input logic [3:0] c);
    byte_t x2;
    byte_t x4;
    byte_t x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns / InvMixColumns on a single 4-byte column.
module mix_column_unit
  import aes_pkg::*;
(
  input  column_t col_in,
  input  logic    inverse,
  output column_t col_out
);

  column_t fwd_col;
  column_t inv_col;

  // Circulant matrix: output row r uses coefficient (j - r) mod 4 for input row j.
  always_comb begin
    fwd_col = '0;
    inv_col = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        fwd_col[~2'(r)] ^= gf_mul_small(col_in[~2'(j)], FWD_COEFS[~2'(j - r)][3:0]);
        inv_col[~2'(r)] ^= gf_mul_small(col_in[~2'(j)], INV_COEFS[~2'(j - r)][3:0]);
      end
    end
  end

  assign col_out = inverse ? inv_col : fwd_col;

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: accepts one state, computes COLS_PER_CYCLE
// columns per clock into a result register, then holds it until taken.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit ENABLE_INV     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  mc_state_e  state;
  mc_state_e  state_next;
  logic [1:0] col_cnt;
  aes_state_t data_q;
  aes_state_t result_q;
  logic       inv_q;

  column_t [COLS_PER_CYCLE-1:0]       unit_out;
  logic    [COLS_PER_CYCLE-1:0][1:0]  unit_col;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    assign unit_col[g] = col_cnt + 2'(g);
    mix_column_unit u_mix (
      .col_in  (data_q[~unit_col[g]]),
      .inverse (inv_q),
      .col_out (unit_out[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (col_cnt == LAST_COL) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // out_valid comes straight from the state register, so an async reset
  // drops it immediately without exposing partial results.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // col_cnt parks on the last column so it only returns to 0 on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      inv_q    <= 1'b0;
      col_cnt  <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q  <= data_in;
            inv_q   <= ENABLE_INV & inverse;
            col_cnt <= '0;
          end
        end
        CALC: begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            result_q[~unit_col[i]] <= unit_out[i];
          end
          if (col_cnt != LAST_COL) col_cnt <= col_cnt + STEP;
        end
        default: ;
      endcase
    end
  end

  assign data_out = result_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter across the 1/2/4 column and
// forward-only configurations, sharing one clock and reset.
module tb_mix_columns_iter;

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V2_IN  = 128'hc6c6c6c6_d4d4d4d5_01010101_db135345;
  localparam logic [127:0] V2_OUT = 128'hc6c6c6c6_d5d5d7d6_01010101_8e4da1bc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [4];
  logic         in_ready  [4];
  logic         inverse   [4];
  logic [127:0] data_in   [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] data_out  [4];
  logic         busy      [4];

  // Instance 0: 1 col, 1: 2 cols, 2: 4 cols, 3: 1 col forward only.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mix_columns_iter #(
      .COLS_PER_CYCLE ((g == 1) ? 2 : ((g == 2) ? 4 : 1)),
      .ENABLE_INV     ((g == 3) ? 1'b0 : 1'b1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .inverse   (inverse[g]),
      .data_in   (data_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  typedef struct {
    int           dut;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   acc_count = 0;
  int   hs_count  = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   k [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [127:0] res = '0;
    if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = 8'(s >> (8 * (15 - (4 * c + j))));
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o ^= gmul(a[j], k[(j - r + 4) % 4]);
        res |= {120'd0, o} << (8 * (15 - (4 * c + r)));
      end
    end
    return res;
  endfunction

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected dut=%0d actual=%0h required=no_output", d, data_out[d]);
          end else begin
            mon_e = exp_q.pop_front();
            check_val($sformatf("sb_dut%0d_src", d), 128'(d), 128'(mon_e.dut));
            check_val($sformatf("sb_dut%0d_data", d), data_out[d], mon_e.data);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic apply_stimulus(input int d, input logic [127:0] data, input logic inv,
                                input bit push, input logic [127:0] expect_val);
    int t = 0;
    while (!in_ready[d] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[d]) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout dut=%0d actual=in_ready_low required=in_ready_high", d);
    end
    in_valid[d] = 1'b1;
    data_in[d]  = data;
    inverse[d]  = inv;
    if (push) begin
      exp_q.push_back('{d, expect_val});
      acc_count++;
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    data_in[d]  = ~data;
    inverse[d]  = ~inv;
  endtask

  task automatic check_output(input int d, input int lat, input string name);
    int cnt = 0;
    while (!out_valid[d] && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_val(name, 128'(cnt), 128'(lat));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_val("drain_queue", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] rnd;
    logic         rinv;
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      inverse[d]   = 1'b0;
      data_in[d]   = '0;
      out_ready[d] = 1'b1;
    end
    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < 4; d++) begin
      check_val($sformatf("rst_flags_dut%0d", d),
                128'({out_valid[d], in_ready[d], busy[d]}), 128'(3'b010));
      check_val($sformatf("rst_data_dut%0d", d), data_out[d], '0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] forward and inverse vectors");
    apply_stimulus(0, V1_IN, 1'b0, 1'b1, V1_OUT);
    check_output(0, 4, "lat_c1_fwd");
    apply_stimulus(0, V1_OUT, 1'b1, 1'b1, V1_IN);
    check_output(0, 4, "lat_c1_inv");
    apply_stimulus(0, V2_IN, 1'b0, 1'b1, V2_OUT);
    apply_stimulus(0, V2_OUT, 1'b1, 1'b1, V2_IN);
    drain();

    $display("[TB] latency sweep");
    apply_stimulus(1, V1_IN, 1'b0, 1'b1, V1_OUT);
    check_output(1, 2, "lat_c2_fwd");
    apply_stimulus(1, V1_OUT, 1'b1, 1'b1, V1_IN);
    apply_stimulus(2, V1_IN, 1'b0, 1'b1, V1_OUT);
    check_output(2, 1, "lat_c4_fwd");
    apply_stimulus(2, V2_OUT, 1'b1, 1'b1, V2_IN);
    drain();

    $display("[TB] forward-only build ignores inverse");
    apply_stimulus(3, V1_IN, 1'b1, 1'b1, V1_OUT);
    check_output(3, 4, "lat_noinv");
    drain();

    $display("[TB] backpressure");
    out_ready[0] = 1'b0;
    apply_stimulus(0, V2_IN, 1'b0, 1'b1, V2_OUT);
    check_output(0, 4, "lat_bp");
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      data_in[0]  = V1_IN;
      inverse[0]  = 1'b1;
      @(posedge clk); #1;
      check_val("bp_data", data_out[0], V2_OUT);
      check_val("bp_flags", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b101));
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_flags", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b010));
    repeat (5) @(posedge clk);
    #1;
    check_val("bp_no_capture", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b010));
    check_val("bp_retain", data_out[0], V2_OUT);

    $display("[TB] reset abort");
    apply_stimulus(0, V1_IN, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("abort_flags", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b010));
    check_val("abort_data", data_out[0], '0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(0, V1_IN, 1'b0, 1'b1, V1_OUT);
    check_output(0, 4, "lat_after_abort");
    drain();

    $display("[TB] random back-to-back");
    for (int d = 0; d < 4; d++) begin
      for (int n = 0; n < 8; n++) begin
        rnd  = {$urandom, $urandom, $urandom, $urandom};
        rinv = 1'($urandom_range(0, 1));
        apply_stimulus(d, rnd, rinv, 1'b1, model_mix(rnd, rinv && (d != 3)));
      end
      drain();
    end

    repeat (3) @(posedge clk);
    #1;
    check_val("handshake_count", 128'(hs_count), 128'(acc_count));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
